// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Latches the decoded control bundle and operands, detects load-use hazards
// (stall + bubble) and squashes the EX slot on a taken branch/jump flush.
// Optional performance counters are enabled with `define ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_result_src,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_alu_src,
  input  logic                  id_alu_a_src,
  input  logic                  id_branch,
  input  logic [1:0]            id_jump,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_pc_plus4,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_funct3,
  input  logic                  id_funct7b5,
  input  logic                  flush,
  input  logic                  stall_ext,
  output logic                  hazard_stall,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic [1:0]            ex_result_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_alu_a_src,
  output logic                  ex_branch,
  output logic [1:0]            ex_jump,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_pc_plus4,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_funct3,
  output logic                  ex_funct7b5
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           perf_bubbles,
  output logic [31:0]           perf_flushes
`endif
);

  // Control bundle packed as {reg_write, result_src, mem_read, mem_write,
  // alu_op, alu_src, alu_a_src, branch, jump}.
  localparam int CTRL_W = 12;

  logic [CTRL_W-1:0]     ctrl_d, ctrl_q;
  logic                  valid_d, valid_q;
  logic [XLEN-1:0]       pc_d, pc_q, pc4_d, pc4_q;
  logic [XLEN-1:0]       rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q;
  logic [XLEN-1:0]       imm_d, imm_q;
  logic [REG_ADDR_W-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [2:0]            funct3_d, funct3_q;
  logic                  funct7b5_d, funct7b5_q;
  logic                  uses_rs1, uses_rs2, hazard;
  logic [CTRL_W-1:0]     id_ctrl;

  assign id_ctrl = {id_reg_write, id_result_src, id_mem_read, id_mem_write,
                    id_alu_op, id_alu_src, id_alu_a_src, id_branch, id_jump};

  // Load-use detection: a load in EX whose rd is read by the decode instruction.
  always_comb begin
    uses_rs1     = id_valid & (id_jump != 2'b01) & (id_result_src != 2'b10) & ~id_alu_a_src;
    uses_rs2     = id_valid & (~id_alu_src | id_mem_write);
    hazard       = valid_q & ex_mem_read & (rd_q != '0) &
                   ((uses_rs1 & (rd_q == id_rs1)) | (uses_rs2 & (rd_q == id_rs2)));
    hazard_stall = hazard & ~flush & ~stall_ext;
  end

  // Next-state selection: flush > external stall > hazard bubble > load.
  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    if (flush || (!stall_ext && hazard)) begin
      // Bubble: control cleared, data fields left as they were.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!stall_ext) begin
      valid_d    = id_valid;
      ctrl_d     = id_valid ? id_ctrl : '0;
      pc_d       = id_pc;
      pc4_d      = id_pc_plus4;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      funct3_d   = id_funct3;
      funct7b5_d = id_funct7b5;
    end
  end

  // Pipeline register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      pc4_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
    end
  end

  assign ex_valid = valid_q;
  assign {ex_reg_write, ex_result_src, ex_mem_read, ex_mem_write,
          ex_alu_op, ex_alu_src, ex_alu_a_src, ex_branch, ex_jump} = ctrl_q;
  assign ex_pc       = pc_q;
  assign ex_pc_plus4 = pc4_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_funct3   = funct3_q;
  assign ex_funct7b5 = funct7b5_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubbles_d, bubbles_q, flushes_d, flushes_q;

  // A hazard bubble is loaded exactly when the stall request is raised.
  always_comb begin
    bubbles_d = hazard_stall ? bubbles_q + 32'd1 : bubbles_q;
    flushes_d = flush ? flushes_q + 32'd1 : flushes_q;
  end

  // Event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      bubbles_q <= bubbles_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_bubbles = bubbles_q;
  assign perf_flushes = flushes_q;
`endif

endmodule
